run_ctrl: RTL and testbench



---
 rtl/run_ctrl_pkg.sv | 14 +
 rtl/btn_debounce.sv | 66 ++++++
 rtl/run_ctrl.sv | 148 ++++++++++++++
 tb/tb_run_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run_ctrl start/stop controller.
package run_ctrl_pkg;

  // Run FSM state; the state bit doubles as the registered run level.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Per-channel mode select values.
  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_STARTSTOP = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchroniser chain, mismatch-count debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_W      = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable_q, stable_d;
  logic                   stable_prev_q;
  logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the raw asynchronous button through the synchroniser chain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Accept a new level only after the mismatch has persisted long enough;
  // any return to agreement restarts the count.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync;
      end else begin
        cnt_d = cnt_q + DEBOUNCE_W'(1);
      end
    end
  end

  // Debounce state and the one-cycle-delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/run_ctrl.sv
// Multi-channel START/STOP controller: debounced buttons drive a per-channel
// IDLE/RUN FSM (toggle or separate start/stop) with registered run level and
// one-cycle start/stop pulses.
// Optional auto-stop after a fixed run length: define RUN_TIMEOUT_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CHANNELS        = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_W      = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_W       = 32,
  parameter int TIMEOUT_CYCLES  = 100000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0] btn_start,
  input  logic [CHANNELS-1:0] btn_stop,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] run,
  output logic [CHANNELS-1:0] start_pulse,
  output logic [CHANNELS-1:0] stop_pulse
`ifdef RUN_TIMEOUT_EN
  ,
  output logic [CHANNELS-1:0] timeout
`endif
);

  // Reject parameter sets the logic cannot honour.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("run_ctrl: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** DEBOUNCE_W) - 1) begin : g_bad_debounce
    $error("run_ctrl: DEBOUNCE_CYCLES out of range for DEBOUNCE_W");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_W < 1) begin : g_bad_timeout
    $error("run_ctrl: TIMEOUT_CYCLES and TIMEOUT_W must be >= 1");
  end

  logic [CHANNELS-1:0] start_press, stop_press;
  logic [CHANNELS-1:0] unused_start_level, unused_stop_level;
  logic [CHANNELS-1:0] expire;

  run_state_e          state_q [CHANNELS];
  logic [CHANNELS-1:0] start_pulse_q, stop_pulse_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_W     (DEBOUNCE_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_start[ch]),
      .level  (unused_start_level[ch]),
      .press  (start_press[ch])
    );

    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_W     (DEBOUNCE_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_stop (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_stop[ch]),
      .level  (unused_stop_level[ch]),
      .press  (stop_press[ch])
    );
  end

`ifdef RUN_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] tmo_cnt_q [CHANNELS];
  logic [CHANNELS-1:0]  timeout_q;

  // A run expires in the cycle its length counter reaches the limit.
  always_comb begin
    expire = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      expire[ch] = (state_q[ch] == ST_RUN) && (tmo_cnt_q[ch] == TMO_LAST);
    end
  end

  assign timeout = timeout_q;
`else
  assign expire = '0;
`endif

  // Per-channel run FSM with registered pulses; stop sources outrank start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pulse_q <= '0;
      stop_pulse_q  <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= ST_IDLE;
`ifdef RUN_TIMEOUT_EN
        tmo_cnt_q[ch] <= '0;
`endif
      end
`ifdef RUN_TIMEOUT_EN
      timeout_q <= '0;
`endif
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        start_pulse_q[ch] <= 1'b0;
        stop_pulse_q[ch]  <= 1'b0;
        if (state_q[ch] == ST_RUN && (clear[ch] || stop_press[ch] || expire[ch])) begin
          state_q[ch]      <= ST_IDLE;
          stop_pulse_q[ch] <= 1'b1;
`ifdef RUN_TIMEOUT_EN
          if (expire[ch]) timeout_q[ch] <= 1'b1;
`endif
        end else if (state_q[ch] == ST_IDLE && start_press[ch] &&
                     !clear[ch] && !stop_press[ch]) begin
          state_q[ch]       <= ST_RUN;
          start_pulse_q[ch] <= 1'b1;
`ifdef RUN_TIMEOUT_EN
          timeout_q[ch] <= 1'b0;
`endif
        end else if (state_q[ch] == ST_RUN && start_press[ch] &&
                     mode[ch] == MODE_TOGGLE) begin
          state_q[ch]      <= ST_IDLE;
          stop_pulse_q[ch] <= 1'b1;
        end
`ifdef RUN_TIMEOUT_EN
        // Counter sits at zero in IDLE so every run starts from a fresh count.
        tmo_cnt_q[ch] <= (state_q[ch] == ST_RUN) ? tmo_cnt_q[ch] + TIMEOUT_W'(1) : '0;
`endif
      end
    end
  end

  // Run level is the state register itself.
  always_comb begin
    run = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      run[ch] = (state_q[ch] == ST_RUN);
    end
  end

  assign start_pulse = start_pulse_q;
  assign stop_pulse  = stop_pulse_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode, btn_start, btn_stop, clear;
  logic [1:0] run, start_pulse, stop_pulse;
`ifdef RUN_TIMEOUT_EN
  logic [1:0] timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_ctrl #(
    .CHANNELS       (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_W     (8),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_W      (8),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .clear      (clear),
    .run        (run),
    .start_pulse(start_pulse),
    .stop_pulse (stop_pulse)
`ifdef RUN_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // run, start_pulse, stop_pulse together.
  task automatic check_outs(input string tag, input logic [1:0] r,
                            input logic [1:0] sp, input logic [1:0] pp);
    check({tag, ".run"}, {6'd0, run}, {6'd0, r});
    check({tag, ".start_pulse"}, {6'd0, start_pulse}, {6'd0, sp});
    check({tag, ".stop_pulse"}, {6'd0, stop_pulse}, {6'd0, pp});
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 2'b00;
    btn_start = 2'b00;
    btn_stop  = 2'b00;
    clear     = 2'b00;
    #1;
    check_outs("reset", 2'b00, 2'b00, 2'b00);
    step(3);
    rst_n = 1'b1;
    step(2);

`ifndef RUN_TIMEOUT_EN
    // Toggle mode, clean press on channel 0: run rises on the 7th edge.
    btn_start = 2'b01;
    step(6);
    check_outs("tog_pre", 2'b00, 2'b00, 2'b00);
    step(1);
    check_outs("tog_start", 2'b01, 2'b01, 2'b00);
    step(1);
    check_outs("tog_start_end", 2'b01, 2'b00, 2'b00);
    step(12);
    btn_start = 2'b00;
    step(10);
    check_outs("tog_release", 2'b01, 2'b00, 2'b00);
    // Second press toggles back to IDLE.
    btn_start = 2'b01;
    step(7);
    check_outs("tog_stop", 2'b00, 2'b00, 2'b01);
    step(1);
    check_outs("tog_stop_end", 2'b00, 2'b00, 2'b00);
    btn_start = 2'b00;
    step(10);

    // Bouncy press on channel 1: 3 high, 1 low, then steady high.
    btn_start = 2'b10;
    step(3);
    btn_start = 2'b00;
    step(1);
    btn_start = 2'b10;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_outs("bounce_quiet", 2'b00, 2'b00, 2'b00);
    end
    step(1);
    check_outs("bounce_start", 2'b10, 2'b10, 2'b00);
    step(1);
    check_outs("bounce_start_end", 2'b10, 2'b00, 2'b00);
    btn_start = 2'b00;
    step(10);

    // One-cycle clear while RUN stops channel 1 only.
    clear = 2'b10;
    step(1);
    clear = 2'b00;
    check_outs("clear_run", 2'b00, 2'b00, 2'b10);
    step(1);
    check_outs("clear_run_end", 2'b00, 2'b00, 2'b00);
    // Clear while IDLE does nothing.
    clear = 2'b11;
    step(1);
    clear = 2'b00;
    check_outs("clear_idle", 2'b00, 2'b00, 2'b00);

    // Start/stop mode: simultaneous start and stop while IDLE, stop wins.
    mode      = 2'b01;
    btn_start = 2'b01;
    btn_stop  = 2'b01;
    step(7);
    check_outs("both_idle", 2'b00, 2'b00, 2'b00);
    step(1);
    check_outs("both_idle2", 2'b00, 2'b00, 2'b00);
    btn_start = 2'b00;
    btn_stop  = 2'b00;
    step(10);
    // Start alone enters RUN.
    btn_start = 2'b01;
    step(7);
    check_outs("ss_start", 2'b01, 2'b01, 2'b00);
    btn_start = 2'b00;
    step(10);
    // Repeated start while RUN: no pulse, stays RUN.
    btn_start = 2'b01;
    step(7);
    check_outs("ss_restart", 2'b01, 2'b00, 2'b00);
    step(1);
    check_outs("ss_restart2", 2'b01, 2'b00, 2'b00);
    btn_start = 2'b00;
    step(10);
    // Stop press ends the run.
    btn_stop = 2'b01;
    step(7);
    check_outs("ss_stop", 2'b00, 2'b00, 2'b01);
    btn_stop = 2'b00;
    step(10);

    // Asynchronous reset mid-RUN drops run at once with no stop pulse.
    btn_start = 2'b01;
    step(7);
    check_outs("pre_reset_run", 2'b01, 2'b01, 2'b00);
    btn_start = 2'b00;
    step(10);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 2'b00, 2'b00, 2'b00);
    #2;
    rst_n = 1'b1;
    step(1);
    check_outs("post_reset", 2'b00, 2'b00, 2'b00);
    // A 3-cycle press is too short to be accepted.
    btn_start = 2'b01;
    step(3);
    btn_start = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_outs("short_press", 2'b00, 2'b00, 2'b00);
    end
`else
    // Auto-stop after exactly 10 cycles of RUN.
    mode      = 2'b01;
    btn_start = 2'b01;
    step(7);
    check_outs("tmo_start", 2'b01, 2'b01, 2'b00);
    check("tmo_start.timeout", {6'd0, timeout}, 8'h00);
    btn_start = 2'b00;
    for (int i = 0; i < 9; i++) begin
      step(1);
      check_outs("tmo_running", 2'b01, 2'b00, 2'b00);
    end
    step(1);
    check_outs("tmo_expire", 2'b00, 2'b00, 2'b01);
    check("tmo_expire.timeout", {6'd0, timeout}, 8'h01);
    step(10);
    check("tmo_sticky", {6'd0, timeout}, 8'h01);
    // Next start clears the sticky flag.
    btn_start = 2'b01;
    step(7);
    check_outs("tmo_restart", 2'b01, 2'b01, 2'b00);
    check("tmo_restart.timeout", {6'd0, timeout}, 8'h00);
    btn_start = 2'b00;
    clear     = 2'b01;
    step(1);
    clear = 2'b00;
    check_outs("tmo_clear", 2'b00, 2'b00, 2'b01);
    check("tmo_clear.timeout", {6'd0, timeout}, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
